// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable synchronous RAM.
package ram_pkg;

   // Widest word byte_merge handles; callers zero-extend into it and truncate the result.
   localparam int unsigned MAX_D_WIDTH  = 1024;
   localparam int unsigned MAX_BE_WIDTH = MAX_D_WIDTH / 8;

   // Clear-sweep controller states (only used when RAM_INIT_CLEAR_EN is defined).
   typedef enum logic {INIT, READY} ram_init_state_t;

   // Number of byte lanes in a data word.
   function automatic int unsigned be_width(input int unsigned d_width);
      return d_width / 8;
   endfunction

   // Replace the byte lanes of old_word selected by be with those of new_word.
   function automatic logic [MAX_D_WIDTH-1:0] byte_merge(
      input logic [MAX_D_WIDTH-1:0]  old_word,
      input logic [MAX_D_WIDTH-1:0]  new_word,
      input logic [MAX_BE_WIDTH-1:0] be
   );
      logic [MAX_D_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MAX_BE_WIDTH; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset clear sweep: writes zero to every entry once, holding the RAM busy meanwhile.
// Only instantiated when RAM_INIT_CLEAR_EN is defined.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int unsigned A_WIDTH = 5,
   parameter int unsigned A_MAX   = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic               init_busy_o,
   output logic               clear_we_o,
   output logic [A_WIDTH-1:0] clear_addr_o
);

   localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(A_MAX - 1);

   ram_init_state_t    state_q, state_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;

   // State and clear-address registers; reset restarts the sweep at address 0.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= INIT;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // One address cleared per cycle; leave INIT after the last entry is written.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      init_busy_o = 1'b0;
      clear_we_o  = 1'b0;
      unique case (state_q)
         INIT: begin
            init_busy_o = 1'b1;
            clear_we_o  = 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d = READY;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         READY: begin
            state_d = READY;
         end
      endcase
   end

   assign clear_addr_o = addr_q;

endmodule

// File: rtl/ram_sync_be.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// a read_valid strobe and selectable read/write collision behaviour.
// Optional feature: define RAM_INIT_CLEAR_EN to zero the whole array after reset.
module ram_sync_be
   import ram_pkg::*;
#(
   parameter int unsigned D_WIDTH      = 8,
   parameter int unsigned A_WIDTH      = 5,
   parameter int unsigned A_MAX        = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned WRITE_FIRST  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        write_enable,
   input  logic [A_WIDTH-1:0]          address_write,
   input  logic [D_WIDTH-1:0]          data_write,
   input  logic [be_width(D_WIDTH)-1:0] byte_enable,
   input  logic                        read_enable,
   input  logic [A_WIDTH-1:0]          address_read,
   output logic [D_WIDTH-1:0]          data_read,
   output logic                        read_valid,
   output logic                        init_busy
);

   localparam int unsigned BE_WIDTH = be_width(D_WIDTH);

   logic [D_WIDTH-1:0]  mem [A_MAX];

   logic                mem_we;
   logic [A_WIDTH-1:0]  mem_addr;
   logic [D_WIDTH-1:0]  mem_wdata;
   logic [BE_WIDTH-1:0] mem_be;
   logic [D_WIDTH-1:0]  merged_word;
   logic                write_hit;
   logic                read_fire;
   logic [D_WIDTH-1:0]  read_word;

`ifdef RAM_INIT_CLEAR_EN
   logic               clear_we;
   logic [A_WIDTH-1:0] clear_addr;

   ram_init_ctrl #(
      .A_WIDTH (A_WIDTH),
      .A_MAX   (A_MAX)
   ) u_init_ctrl (
      .clk_i        (clk),
      .reset_i      (reset),
      .init_busy_o  (init_busy),
      .clear_we_o   (clear_we),
      .clear_addr_o (clear_addr)
   );
`else
   assign init_busy = 1'b0;
`endif

   // Write-port mux: user writes normally, the clear sweep takes over while busy.
   always_comb begin
      write_hit = write_enable && !init_busy && (32'(address_write) < A_MAX);
      mem_we    = write_hit;
      mem_addr  = address_write;
      mem_wdata = data_write;
      mem_be    = byte_enable;
`ifdef RAM_INIT_CLEAR_EN
      if (clear_we) begin
         mem_we    = 1'b1;
         mem_addr  = clear_addr;
         mem_wdata = '0;
         mem_be    = '1;
      end
`endif
      merged_word = D_WIDTH'(byte_merge(MAX_D_WIDTH'(mem[mem_addr]), MAX_D_WIDTH'(mem_wdata),
                                        MAX_BE_WIDTH'(mem_be)));
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= merged_word;
   end

   // Read word selection, including out-of-range and same-address collision handling.
   always_comb begin
      read_fire = read_enable && !init_busy;
      if (32'(address_read) >= A_MAX) begin
         read_word = '0;
      end else if ((WRITE_FIRST != 0) && write_hit && (address_write == address_read)) begin
         read_word = merged_word;
      end else begin
         read_word = mem[address_read];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [D_WIDTH-1:0] stage_data_q;
      logic               stage_valid_q;

      // Capture stage followed by a plain output register; reset flushes both.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stage_data_q  <= '0;
            stage_valid_q <= 1'b0;
            data_read     <= '0;
            read_valid    <= 1'b0;
         end else begin
            stage_valid_q <= read_fire;
            if (read_fire) stage_data_q <= read_word;
            read_valid <= stage_valid_q;
            if (stage_valid_q) data_read <= stage_data_q;
         end
      end
   end else begin : g_lat1
      // Single output register; data_read holds between strobes.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data_read  <= '0;
            read_valid <= 1'b0;
         end else begin
            read_valid <= read_fire;
            if (read_fire) data_read <= read_word;
         end
      end
   end

endmodule

// File: tb/tb_ram_sync_be.sv
// Bench for ram_sync_be: two instances share stimulus, one with latency 1 / read-first /
// 32 entries and one with latency 2 / write-first / 24 entries. Build with and without
// RAM_INIT_CLEAR_EN to cover the clear sweep.
module tb_ram_sync_be;

   localparam int AMAX_A = 32;
   localparam int AMAX_B = 24;
   localparam int RL_A   = 1;
   localparam int RL_B   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        write_enable;
   logic [4:0]  address_write;
   logic [31:0] data_write;
   logic [3:0]  byte_enable;
   logic        read_enable;
   logic [4:0]  address_read;
   logic [31:0] data_read_a, data_read_b;
   logic        read_valid_a, read_valid_b;
   logic        init_busy_a, init_busy_b;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        re;
      logic [4:0]  ra;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   vec_t        tbl[17];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          init_left_a = 0;
   int          init_left_b = 0;
   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;

   always #5 clk = ~clk;

   ram_sync_be #(
      .D_WIDTH(32), .A_WIDTH(5), .A_MAX(AMAX_A), .READ_LATENCY(RL_A), .WRITE_FIRST(0)
   ) dut_a (
      .clk(clk), .reset(reset), .write_enable(write_enable), .address_write(address_write),
      .data_write(data_write), .byte_enable(byte_enable), .read_enable(read_enable),
      .address_read(address_read), .data_read(data_read_a), .read_valid(read_valid_a),
      .init_busy(init_busy_a)
   );

   ram_sync_be #(
      .D_WIDTH(32), .A_WIDTH(5), .A_MAX(AMAX_B), .READ_LATENCY(RL_B), .WRITE_FIRST(1)
   ) dut_b (
      .clk(clk), .reset(reset), .write_enable(write_enable), .address_write(address_write),
      .data_write(data_write), .byte_enable(byte_enable), .read_enable(read_enable),
      .address_read(address_read), .data_read(data_read_b), .read_valid(read_valid_b),
      .init_busy(init_busy_b)
   );

   function automatic vec_t mkv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic re, input logic [4:0] ra,
                                input logic [31:0] ea, input logic [31:0] eb);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.be = be;
      v.re = re; v.ra = ra; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   function automatic logic [31:0] wval(input int i);
      return {8'(i), 8'hA5, 8'(i + 1), 8'h3C};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
      end
   endtask

   task automatic set_idle();
      write_enable  = 1'b0;
      address_write = '0;
      data_write    = '0;
      byte_enable   = '0;
      read_enable   = 1'b0;
      address_read  = '0;
   endtask

   // Compare both instances against the head of their scoreboards for this cycle.
   task automatic check_outputs();
      exp_t e;
      if (q_a.size() != 0 && q_a[0].due == cyc) begin
         e = q_a.pop_front();
         chk("a_valid", 32'(read_valid_a), 32'd1);
         chk("a_data", data_read_a, e.data);
         last_a = e.data;
      end else begin
         chk("a_valid_idle", 32'(read_valid_a), 32'd0);
         chk("a_hold", data_read_a, last_a);
      end
      if (q_b.size() != 0 && q_b[0].due == cyc) begin
         e = q_b.pop_front();
         chk("b_valid", 32'(read_valid_b), 32'd1);
         chk("b_data", data_read_b, e.data);
         last_b = e.data;
      end else begin
         chk("b_valid_idle", 32'(read_valid_b), 32'd0);
         chk("b_hold", data_read_b, last_b);
      end
   endtask

   // One clock: check busy, drive a vector, queue expected reads, clock, check outputs.
   task automatic step(input vec_t v);
      exp_t e;
      chk("a_busy", 32'(init_busy_a), 32'(init_left_a != 0));
      chk("b_busy", 32'(init_busy_b), 32'(init_left_b != 0));
      write_enable  = v.we;
      address_write = v.wa;
      data_write    = v.wd;
      byte_enable   = v.be;
      read_enable   = v.re;
      address_read  = v.ra;
      if (v.re && init_left_a == 0) begin
         e.data = v.exp_a; e.due = cyc + 1 + RL_A - 1;
         q_a.push_back(e);
      end
      if (v.re && init_left_b == 0) begin
         e.data = v.exp_b; e.due = cyc + 1 + RL_B - 1;
         q_b.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (init_left_a > 0) init_left_a--;
      if (init_left_b > 0) init_left_b--;
      check_outputs();
   endtask

   // Assert reset (optionally checking the asynchronous clear), hold, then release.
   task automatic do_reset(input int hold, input bit check_now);
      logic [31:0] busy_exp;
`ifdef RAM_INIT_CLEAR_EN
      busy_exp = 32'd1;
`else
      busy_exp = 32'd0;
`endif
      reset = 1'b1;
      set_idle();
      #1;
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
      if (check_now) begin
         chk("rst_a_valid", 32'(read_valid_a), 32'd0);
         chk("rst_b_valid", 32'(read_valid_b), 32'd0);
         chk("rst_a_data", data_read_a, 32'd0);
         chk("rst_b_data", data_read_b, 32'd0);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("rst_a_valid", 32'(read_valid_a), 32'd0);
         chk("rst_b_valid", 32'(read_valid_b), 32'd0);
         chk("rst_a_data", data_read_a, 32'd0);
         chk("rst_b_data", data_read_b, 32'd0);
         chk("rst_a_busy", 32'(init_busy_a), busy_exp);
         chk("rst_b_busy", 32'(init_busy_b), busy_exp);
      end
      reset = 1'b0;
`ifdef RAM_INIT_CLEAR_EN
      init_left_a = AMAX_A;
      init_left_b = AMAX_B;
`else
      init_left_a = 0;
      init_left_b = 0;
`endif
   endtask

   initial begin
      vec_t idle;
      idle = mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 32'h0);

      //            we    wa     wd            be    re    ra     exp_a         exp_b
      tbl[0]  = mkv(1'b1, 5'd27, 32'h00000000, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[1]  = mkv(1'b1, 5'd27, 32'hFFFFFFC5, 4'h1, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[2]  = mkv(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd27, 32'h000000C5, 32'h0);
      tbl[3]  = mkv(1'b1, 5'd3,  32'hAABBCCDD, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[4]  = mkv(1'b1, 5'd3,  32'h11223344, 4'h5, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[5]  = mkv(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  32'hAA22CC44, 32'hAA22CC44);
      tbl[6]  = mkv(1'b1, 5'd7,  32'h0000005A, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[7]  = mkv(1'b1, 5'd7,  32'hFFFFFFA5, 4'h1, 1'b1, 5'd7,  32'h0000005A, 32'h000000A5);
      tbl[8]  = mkv(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd7,  32'h000000A5, 32'h000000A5);
      tbl[9]  = mkv(1'b1, 5'd3,  32'hFFFFFFFF, 4'h0, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[10] = mkv(1'b1, 5'd20, 32'hDEADBEEF, 4'hF, 1'b1, 5'd3,  32'hAA22CC44, 32'hAA22CC44);
      tbl[11] = mkv(1'b1, 5'd9,  32'h99999999, 4'hF, 1'b1, 5'd20, 32'hDEADBEEF, 32'hDEADBEEF);
      tbl[12] = mkv(1'b1, 5'd25, 32'h12345678, 4'hF, 1'b0, 5'd0,  32'h0,        32'h0);
      tbl[13] = mkv(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd25, 32'h12345678, 32'h0);
      tbl[14] = mkv(1'b1, 5'd9,  32'hA1B2C3D4, 4'hA, 1'b1, 5'd9,  32'h99999999, 32'hA199C399);
      tbl[15] = mkv(1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd9,  32'hA199C399, 32'hA199C399);
      tbl[16] = idle;

      set_idle();
      do_reset(2, 1'b0);

`ifdef RAM_INIT_CLEAR_EN
      // Reset part-way through the sweep must restart it from the beginning.
      for (int i = 0; i < 5; i++) step(idle);
      do_reset(1, 1'b1);
      // Accesses while both instances are still clearing are dropped.
      for (int i = 0; i < AMAX_B; i++) begin
         step(mkv(1'b1, 5'(i), 32'hFFFFFFFF, 4'hF, 1'b1, 5'(i), 32'h0, 32'h0));
      end
      for (int i = AMAX_B; i < AMAX_A; i++) step(idle);
      for (int i = 0; i < AMAX_A; i++) begin
         step(mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 32'h0, 32'h0));
      end
`endif

      foreach (tbl[i]) step(tbl[i]);

      // Back-to-back reads return one word per cycle, in order.
      for (int i = 0; i < 8; i++) step(mkv(1'b1, 5'(i), wval(i), 4'hF, 1'b0, 5'd0, 32'h0, 32'h0));
      for (int i = 0; i < 8; i++) step(mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), wval(i), wval(i)));
      for (int i = 0; i < 3; i++) step(idle);

      // Reset after the third request flushes everything still in flight.
      for (int i = 0; i < 3; i++) step(mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), wval(i), wval(i)));
      do_reset(2, 1'b1);
      for (int i = 0; i < AMAX_A + 2; i++) step(idle);
`ifdef RAM_INIT_CLEAR_EN
      step(mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'h0, 32'h0));
`else
      step(mkv(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, wval(5), wval(5)));
`endif
      for (int i = 0; i < 3; i++) step(idle);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
